// File: rtl/call_stack_if.sv
// Command/status bundle between the SAP-2 controller/bus and the call stack.
// The master drives commands and bus data; the slave returns stack state.
interface call_stack_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 5
);
    logic                   i_push;
    logic                   i_pop;
    logic                   i_clear_err;
    logic [DATA_WIDTH-1:0]  i_bus_data;
    logic [DATA_WIDTH-1:0]  o_stack_data;
    logic [COUNT_WIDTH-1:0] o_count;
    logic                   o_empty;
    logic                   o_full;
    logic                   o_overflow;
    logic                   o_underflow;

    modport master (
        output i_push, i_pop, i_clear_err, i_bus_data,
        input  o_stack_data, o_count, o_empty, o_full,
        input  o_overflow, o_underflow
    );

    modport slave (
        input  i_push, i_pop, i_clear_err, i_bus_data,
        output o_stack_data, o_count, o_empty, o_full,
        output o_overflow, o_underflow
    );
endinterface

// File: rtl/call_stack.sv
// LIFO return-address stack with a registered top-of-stack copy,
// saturating occupancy count and sticky overflow/underflow flags.
module call_stack #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input logic        i_clk,
    input logic        i_reset,
    call_stack_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  top_q, top_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    logic                   we;
    logic [IDX_W-1:0]       waddr;
    logic [IDX_W-1:0]       top_idx;
    logic [IDX_W-1:0]       below_idx;
    logic                   is_empty;
    logic                   is_full;
    logic                   ovf_set;
    logic                   unf_set;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == COUNT_WIDTH'(DEPTH));

    // Indices are forced to 0 when the count cannot support them,
    // so the array is never addressed out of range.
    assign top_idx   = is_empty ? '0
                     : IDX_W'(count_q - COUNT_WIDTH'(1));
    assign below_idx = (count_q > COUNT_WIDTH'(1))
                     ? IDX_W'(count_q - COUNT_WIDTH'(2)) : '0;

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        we      = 1'b0;
        waddr   = top_idx;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (bus.i_push && bus.i_pop) begin
            we    = 1'b1;
            top_d = bus.i_bus_data;
            if (is_empty) begin
                waddr   = '0;
                count_d = COUNT_WIDTH'(1);
                unf_set = 1'b1;
            end
        end else if (bus.i_push) begin
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                we      = 1'b1;
                waddr   = IDX_W'(count_q);
                count_d = count_q + COUNT_WIDTH'(1);
                top_d   = bus.i_bus_data;
            end
        end else if (bus.i_pop) begin
            if (count_q > COUNT_WIDTH'(1)) begin
                count_d = count_q - COUNT_WIDTH'(1);
                top_d   = mem_q[below_idx];
            end else if (!is_empty) begin
                count_d = '0;
                top_d   = '0;
            end else begin
                unf_set = 1'b1;
            end
        end

        // A fresh error beats a clear in the same cycle.
        ovf_d = ovf_set | (ovf_q & ~bus.i_clear_err);
        unf_d = unf_set | (unf_q & ~bus.i_clear_err);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_q[waddr] <= bus.i_bus_data;
        end
    end

    assign bus.o_stack_data = top_q;
    assign bus.o_count      = count_q;
    assign bus.o_empty      = is_empty;
    assign bus.o_full       = is_full;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_underflow  = unf_q;
endmodule
